pipeline_control: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline. Drives the load enables and bubble (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use and RAW hazards, data-memory wait states and control-flow redirects. Also produces EX-stage forwarding selects and a stall performance counter.

---
 rtl/pipeline_control.sv | 168 ++++++++++++++++
 tb/tb_pipeline_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Hazard/sequencing controller for the five-stage MIPS pipeline: enables, bubbles,
// redirects, EX forwarding selects and a stall counter. Optional macro: FORWARD_EN.
module pipeline_control #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       in_IDrs,
    input  logic [4:0]       in_IDrt,
    input  logic             in_IDUsesRs,
    input  logic             in_IDUsesRt,
    input  logic             in_EXMemRead,
    input  logic             in_EXRegWrite,
    input  logic [4:0]       in_EXWriteRegister,
    input  logic             in_MEMRegWrite,
    input  logic [4:0]       in_MEMWriteRegister,
    input  logic             in_MEMReq,
    input  logic             in_MEMReady,
    input  logic             in_Redirect,
    output logic             out_PCEn,
    output logic             out_IFIDEn,
    output logic             out_IDEXEn,
    output logic             out_EXMEMEn,
    output logic             out_MEMWBEn,
    output logic             out_IFIDFlush,
    output logic             out_IDEXFlush,
    output logic             out_EXMEMFlush,
    output logic             out_MEMWBFlush,
    output logic             out_PCRedirect,
    output logic [1:0]       out_ForwardA,
    output logic [1:0]       out_ForwardB,
    output logic [CNT_W-1:0] out_StallCount,
    output logic             out_MemTimeout
);

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;
    localparam int   WCNT_W      = $clog2(MEM_TIMEOUT + 1);

    logic              r_st;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_rpend;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_mem_timeout;

    logic w_rs_valid;
    logic w_rt_valid;
    logic w_ex_match_rs;
    logic w_ex_match_rt;
    logic w_mem_match_rs;
    logic w_mem_match_rt;
    logic w_load_use;
    logic w_data_hazard;
    logic w_wait_left;
    logic w_mem_stall;
    logic w_redirect;
    logic w_timeout_exit;

    // A zero source never matches, so register 0 cannot stall or forward.
    assign w_rs_valid     = in_IDUsesRs && (in_IDrs != 5'd0);
    assign w_rt_valid     = in_IDUsesRt && (in_IDrt != 5'd0);
    assign w_ex_match_rs  = w_rs_valid && (in_IDrs == in_EXWriteRegister);
    assign w_ex_match_rt  = w_rt_valid && (in_IDrt == in_EXWriteRegister);
    assign w_mem_match_rs = w_rs_valid && (in_IDrs == in_MEMWriteRegister);
    assign w_mem_match_rt = w_rt_valid && (in_IDrt == in_MEMWriteRegister);
    assign w_load_use     = in_EXMemRead && (w_ex_match_rs || w_ex_match_rt);

`ifdef FORWARD_EN
    assign w_data_hazard = w_load_use;

    always_comb begin
        out_ForwardA = 2'b00;
        out_ForwardB = 2'b00;
        if (in_EXRegWrite && w_ex_match_rs)
            out_ForwardA = 2'b10;
        else if (in_MEMRegWrite && w_mem_match_rs)
            out_ForwardA = 2'b01;
        if (in_EXRegWrite && w_ex_match_rt)
            out_ForwardB = 2'b10;
        else if (in_MEMRegWrite && w_mem_match_rt)
            out_ForwardB = 2'b01;
    end
`else
    assign w_data_hazard = w_load_use
                         || (in_EXRegWrite  && (w_ex_match_rs  || w_ex_match_rt))
                         || (in_MEMRegWrite && (w_mem_match_rs || w_mem_match_rt));
    assign out_ForwardA  = 2'b00;
    assign out_ForwardB  = 2'b00;
`endif

    assign w_wait_left    = (r_wcnt < WCNT_W'(MEM_TIMEOUT));
    assign w_mem_stall    = in_MEMReq && !in_MEMReady && w_wait_left;
    assign w_redirect     = in_Redirect || r_rpend;
    assign w_timeout_exit = (r_st == ST_MEM_WAIT) && in_MEMReq && !in_MEMReady && !w_wait_left;

    always_comb begin
        out_PCEn       = 1'b1;
        out_IFIDEn     = 1'b1;
        out_IDEXEn     = 1'b1;
        out_EXMEMEn    = 1'b1;
        out_MEMWBEn    = 1'b1;
        out_IFIDFlush  = 1'b0;
        out_IDEXFlush  = 1'b0;
        out_EXMEMFlush = 1'b0;
        out_MEMWBFlush = 1'b0;
        out_PCRedirect = 1'b0;
        if (rst) begin
            out_IFIDFlush  = 1'b1;
            out_IDEXFlush  = 1'b1;
            out_EXMEMFlush = 1'b1;
            out_MEMWBFlush = 1'b1;
        end else if (w_mem_stall) begin
            // Freeze up to EX/MEM; WB receives a bubble while memory is busy.
            out_PCEn       = 1'b0;
            out_IFIDEn     = 1'b0;
            out_IDEXEn     = 1'b0;
            out_EXMEMEn    = 1'b0;
            out_MEMWBFlush = 1'b1;
        end else if (w_redirect) begin
            out_PCRedirect = 1'b1;
            out_IFIDFlush  = 1'b1;
            out_IDEXFlush  = 1'b1;
            out_EXMEMFlush = 1'b1;
        end else if (w_data_hazard) begin
            out_PCEn      = 1'b0;
            out_IFIDEn    = 1'b0;
            out_IDEXFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st          <= ST_RUN;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_mem_stall) begin
            r_st   <= ST_MEM_WAIT;
            r_wcnt <= r_wcnt + 1'b1;
        end else begin
            r_st   <= ST_RUN;
            r_wcnt <= '0;
            if (w_timeout_exit)
                r_mem_timeout <= 1'b1;
        end
    end

    // A redirect arriving while memory stalls is held until the first free cycle.
    always_ff @(posedge clk) begin
        if (rst)
            r_rpend <= 1'b0;
        else if (w_mem_stall)
            r_rpend <= r_rpend || in_Redirect;
        else if (w_redirect)
            r_rpend <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (!out_PCEn && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign out_StallCount = r_stall_cnt;
    assign out_MemTimeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control with MEM_TIMEOUT=4; covers both FORWARD_EN builds.
module tb_pipeline_control;

    // Control bundle: {PCEn,IFIDEn,IDEXEn,EXMEMEn,MEMWBEn,IFIDFl,IDEXFl,EXMEMFl,MEMWBFl,PCRedirect}
    localparam logic [9:0] C_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] C_RESET = 10'b11111_1111_0;
    localparam logic [9:0] C_MEMST = 10'b00001_0001_0;
    localparam logic [9:0] C_REDIR = 10'b11111_1110_1;
    localparam logic [9:0] C_LDUSE = 10'b00111_0100_0;

    logic        clk;
    logic        rst;
    logic [4:0]  in_IDrs, in_IDrt;
    logic        in_IDUsesRs, in_IDUsesRt;
    logic        in_EXMemRead, in_EXRegWrite;
    logic [4:0]  in_EXWriteRegister;
    logic        in_MEMRegWrite;
    logic [4:0]  in_MEMWriteRegister;
    logic        in_MEMReq, in_MEMReady, in_Redirect;
    logic        out_PCEn, out_IFIDEn, out_IDEXEn, out_EXMEMEn, out_MEMWBEn;
    logic        out_IFIDFlush, out_IDEXFlush, out_EXMEMFlush, out_MEMWBFlush;
    logic        out_PCRedirect;
    logic [1:0]  out_ForwardA, out_ForwardB;
    logic [15:0] out_StallCount;
    logic        out_MemTimeout;
    logic [9:0]  w_ctl;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    pipeline_control #(
        .MEM_TIMEOUT(4),
        .CNT_W      (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_IDrs            (in_IDrs),
        .in_IDrt            (in_IDrt),
        .in_IDUsesRs        (in_IDUsesRs),
        .in_IDUsesRt        (in_IDUsesRt),
        .in_EXMemRead       (in_EXMemRead),
        .in_EXRegWrite      (in_EXRegWrite),
        .in_EXWriteRegister (in_EXWriteRegister),
        .in_MEMRegWrite     (in_MEMRegWrite),
        .in_MEMWriteRegister(in_MEMWriteRegister),
        .in_MEMReq          (in_MEMReq),
        .in_MEMReady        (in_MEMReady),
        .in_Redirect        (in_Redirect),
        .out_PCEn           (out_PCEn),
        .out_IFIDEn         (out_IFIDEn),
        .out_IDEXEn         (out_IDEXEn),
        .out_EXMEMEn        (out_EXMEMEn),
        .out_MEMWBEn        (out_MEMWBEn),
        .out_IFIDFlush      (out_IFIDFlush),
        .out_IDEXFlush      (out_IDEXFlush),
        .out_EXMEMFlush     (out_EXMEMFlush),
        .out_MEMWBFlush     (out_MEMWBFlush),
        .out_PCRedirect     (out_PCRedirect),
        .out_ForwardA       (out_ForwardA),
        .out_ForwardB       (out_ForwardB),
        .out_StallCount     (out_StallCount),
        .out_MemTimeout     (out_MemTimeout)
    );

    assign w_ctl = {out_PCEn, out_IFIDEn, out_IDEXEn, out_EXMEMEn, out_MEMWBEn,
                    out_IFIDFlush, out_IDEXFlush, out_EXMEMFlush, out_MEMWBFlush,
                    out_PCRedirect};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_IDrs = 5'd0; in_IDrt = 5'd0; in_IDUsesRs = 1'b0; in_IDUsesRt = 1'b0;
        in_EXMemRead = 1'b0; in_EXRegWrite = 1'b0; in_EXWriteRegister = 5'd0;
        in_MEMRegWrite = 1'b0; in_MEMWriteRegister = 5'd0;
        in_MEMReq = 1'b0; in_MEMReady = 1'b0; in_Redirect = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        check("reset_ctl", 32'(w_ctl), 32'(C_RESET));
        step();
        rst = 1'b0;
        #1;
        check("reset_cnt", 32'(out_StallCount), 32'd0);
        check("reset_tmo", 32'(out_MemTimeout), 32'd0);
        check("idle_ctl", 32'(w_ctl), 32'(C_RUN));

        // Load-use: lw $t0 in EX, ID reads $t0.
        in_EXMemRead = 1'b1; in_EXRegWrite = 1'b1; in_EXWriteRegister = 5'd8;
        in_IDrs = 5'd8; in_IDUsesRs = 1'b1;
        #1;
        check("ldu_ctl", 32'(w_ctl), 32'(C_LDUSE));
        step();
        in_EXMemRead = 1'b0; in_EXRegWrite = 1'b0; in_EXWriteRegister = 5'd0;
        #1;
        check("ldu_after", 32'(w_ctl), 32'(C_RUN));
        check("ldu_cnt", 32'(out_StallCount), 32'd1);

        // Register 0 and unused sources never stall.
        in_EXMemRead = 1'b1; in_EXWriteRegister = 5'd0; in_IDrs = 5'd0; in_IDUsesRs = 1'b1;
        #1;
        check("zero_reg", 32'(w_ctl), 32'(C_RUN));
        in_EXWriteRegister = 5'd7; in_IDrt = 5'd7; in_IDUsesRt = 1'b0;
        #1;
        check("unused_rt", 32'(w_ctl), 32'(C_RUN));

        // Three wait cycles, release on the fourth.
        do_reset();
        in_MEMReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_stall", 32'(w_ctl), 32'(C_MEMST));
            step();
        end
        in_MEMReady = 1'b1;
        #1;
        check("mw_release", 32'(w_ctl), 32'(C_RUN));
        step();
        idle();
        #1;
        check("mw_cnt", 32'(out_StallCount), 32'd3);
        check("mw_tmo", 32'(out_MemTimeout), 32'd0);

        // Redirect during a 2-cycle wait is applied in the release cycle.
        do_reset();
        in_MEMReq = 1'b1; in_Redirect = 1'b1;
        #1;
        check("rd_stall1", 32'(w_ctl), 32'(C_MEMST));
        step();
        in_Redirect = 1'b0;
        #1;
        check("rd_stall2", 32'(w_ctl), 32'(C_MEMST));
        step();
        in_MEMReady = 1'b1;
        #1;
        check("rd_release", 32'(w_ctl), 32'(C_REDIR));
        step();
        idle();
        #1;
        check("rd_cleared", 32'(w_ctl), 32'(C_RUN));

        // Timeout with MEM_TIMEOUT=4.
        do_reset();
        in_MEMReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_stall", 32'(w_ctl), 32'(C_MEMST));
            step();
        end
        #1;
        check("to_advance", 32'(w_ctl), 32'(C_RUN));
        step();
        idle();
        #1;
        check("to_flag", 32'(out_MemTimeout), 32'd1);
        check("to_cnt", 32'(out_StallCount), 32'd4);
        step();
        step();
        check("to_sticky", 32'(out_MemTimeout), 32'd1);

        // EX and MEM both write $t1, ID reads $t1 on rs and rt.
        do_reset();
        in_EXRegWrite = 1'b1; in_EXWriteRegister = 5'd9;
        in_MEMRegWrite = 1'b1; in_MEMWriteRegister = 5'd9;
        in_IDrs = 5'd9; in_IDUsesRs = 1'b1; in_IDrt = 5'd9; in_IDUsesRt = 1'b1;
        #1;
`ifdef FORWARD_EN
        check("fw_ctl", 32'(w_ctl), 32'(C_RUN));
        check("fw_a_ex", 32'(out_ForwardA), 32'd2);
        check("fw_b_ex", 32'(out_ForwardB), 32'd2);
        in_EXRegWrite = 1'b0;
        #1;
        check("fw_a_mem", 32'(out_ForwardA), 32'd1);
        in_IDrt = 5'd0;
        #1;
        check("fw_b_zero", 32'(out_ForwardB), 32'd0);
`else
        check("nf_stall1", 32'(w_ctl), 32'(C_LDUSE));
        check("nf_fwa", 32'(out_ForwardA), 32'd0);
        check("nf_fwb", 32'(out_ForwardB), 32'd0);
        step();
        in_EXRegWrite = 1'b0; in_EXWriteRegister = 5'd0;
        #1;
        check("nf_stall2", 32'(w_ctl), 32'(C_LDUSE));
        step();
        in_MEMRegWrite = 1'b0; in_MEMWriteRegister = 5'd0;
        #1;
        check("nf_clear", 32'(w_ctl), 32'(C_RUN));
        check("nf_cnt", 32'(out_StallCount), 32'd2);
`endif

        // Reset in MEM_WAIT with a pending redirect.
        do_reset();
        in_MEMReq = 1'b1; in_Redirect = 1'b1;
        step();
        in_Redirect = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("rw_ctl", 32'(w_ctl), 32'(C_RESET));
        step();
        rst = 1'b0;
        idle();
        #1;
        check("rw_noredir", 32'(w_ctl), 32'(C_RUN));
        check("rw_cnt", 32'(out_StallCount), 32'd0);
        check("rw_tmo", 32'(out_MemTimeout), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
